// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants and immediate format enum
package rv32_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_SHAMT,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32I immediate format decode and extraction
module imm_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instruction,
    output imm_fmt_e    fmt,
    output logic [31:0] imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sign;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign sign   = instruction[31];

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP_IMM: begin
                // slli/srli/srai carry a shift amount, not a signed immediate
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt = FMT_SHAMT;
                end else begin
                    fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = 32'h0000_0000;
        case (fmt)
            FMT_I:     imm = {{20{sign}}, instruction[31:20]};
            FMT_SHAMT: imm = {27'b0, instruction[24:20]};
            FMT_S:     imm = {{20{sign}}, instruction[31:25], instruction[11:7]};
            FMT_B:     imm = {{19{sign}}, sign, instruction[7], instruction[30:25],
                              instruction[11:8], 1'b0};
            FMT_U:     imm = {instruction[31:12], 12'b0};
            FMT_J:     imm = {{11{sign}}, sign, instruction[19:12], instruction[20],
                              instruction[30:21], 1'b0};
            default:   imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/immediate_gen.sv
// rtl/immediate_gen.sv - registered RV32I immediate generator with async active-low reset
module immediate_gen
    import rv32_pkg::*;
(
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    output logic [31:0] immediate
);

    imm_fmt_e    fmt;
    logic [31:0] imm_raw;
    logic [31:0] imm_d;

    imm_decode u_imm_decode (
        .instruction (instruction),
        .fmt         (fmt),
        .imm         (imm_raw)
    );

    assign imm_d = (fmt == FMT_NONE) ? 32'h0000_0000 : imm_raw;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            immediate <= 32'h0000_0000;
        end else begin
            immediate <= imm_d;
        end
    end

endmodule

// File: tb/tb_immediate_gen.sv
// tb/tb_immediate_gen.sv - self-checking bench for immediate_gen against a behavioural decode model
module tb_immediate_gen;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] immediate;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_imm;
    bit          chk_en  = 1'b0;

    logic [6:0]  opcs [11] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0110011, 7'b1110011, 7'b0001111};

    initial forever #5 sysclk = ~sysclk;

    immediate_gen dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .immediate   (immediate)
    );

    // Immediate value from the ISA field layout: gather the field as an unsigned number, then two's-complement it by width
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        longint f;
        int     w;
        f = 0;
        w = 0;
        case (i[6:0])
            7'b0010011: begin
                if (i[14:12] == 3'b001 || i[14:12] == 3'b101) return 32'(i[24:20]);
                f = longint'(i[31:20]); w = 12;
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                f = longint'(i[31:20]); w = 12;
            end
            7'b0100011: begin
                f = longint'(i[31:25]) * 32 + longint'(i[11:7]); w = 12;
            end
            7'b1100011: begin
                f = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                w = 13;
            end
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1101111: begin
                f = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                w = 21;
            end
            default: return 32'h0;
        endcase
        if (i[31]) f = f - (longint'(1) << w);
        return f[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic apply(input string name, input logic [31:0] instr, input logic [31:0] want);
        @(negedge sysclk);
        instruction = instr;
        @(posedge sysclk);
        #1;
        check(name, immediate, want);
    endtask

    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) exp_imm <= 32'h0;
        else          exp_imm <= ref_imm(instruction);
    end

    always @(negedge sysclk) begin
        if (chk_en) begin
            n_tests++;
            if (immediate !== exp_imm) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, immediate, exp_imm);
            end
        end
    end

    initial begin
        reset_n     = 1'b1;
        instruction = 32'h02a00293;
        #1 reset_n  = 1'b0;
        #1 check("reset_async", immediate, 32'h0);

        check("model_addi", ref_imm(32'h02a00293), 32'h0000_002A);
        check("model_beq",  ref_imm(32'h01c38463), 32'h0000_0008);
        check("model_sw",   ref_imm(32'hFE552E23), 32'hFFFF_FFFC);
        check("model_jal",  ref_imm(32'hFFDFF06F), 32'hFFFF_FFFC);
        check("model_srai", ref_imm(32'h4030D093), 32'h0000_0003);

        @(negedge sysclk);
        check("reset_hold_edge", immediate, 32'h0);
        reset_n = 1'b1;
        @(posedge sysclk);
        #1 check("reset_release", immediate, 32'h0000_002A);
        chk_en = 1'b1;

        apply("addi", 32'h02a00293, 32'h0000_002A);
        apply("lw",   32'h00052283, 32'h0000_0000);
        apply("beq",  32'h01c38463, 32'h0000_0008);

        #2 reset_n = 1'b0;
        #1 check("midreset_async", immediate, 32'h0);
        repeat (2) @(posedge sysclk);
        #1 check("midreset_hold", immediate, 32'h0);
        @(negedge sysclk);
        reset_n = 1'b1;

        apply("add",  32'h006283b3, 32'h0000_0000);
        apply("sw",   32'hFE552E23, 32'hFFFF_FFFC);
        apply("jal",  32'hFFDFF06F, 32'hFFFF_FFFC);
        apply("lui",  32'h123450B7, 32'h1234_5000);
        apply("srai", 32'h4030D093, 32'h0000_0003);

        for (int k = 0; k < 1000; k++) begin
            logic [31:0] r;
            @(negedge sysclk);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = opcs[$urandom_range(0, 10)];
            instruction = r;
        end
        @(negedge sysclk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/immediate_gen.md
Name: immediate_gen

Overview:
RV32I immediate generator for the single-cycle/simple RISC-V datapath. It decodes the instruction format from the opcode, then extracts and sign-extends the immediate. The result is registered on sysclk and feeds the ALU B-mux, the load/store address adder and the branch/jump target adder. R-type and unknown opcodes yield zero.

Parameters:
None. Widths are fixed: 32-bit instruction, 32-bit immediate.

Ports:
sysclk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
instruction  input  32  raw RV32I instruction word
immediate  output  32  decoded, sign-extended immediate (registered)

Behaviour:
- Async reset: reset_n low forces immediate = 32'h0000_0000 immediately, independent of sysclk. Release is synchronous to the next rising edge.
- Latency: 1 cycle. On each rising sysclk with reset_n high, immediate <= decode(instruction). Output is stable between edges.
- The instruction must be stable for setup time before the capturing edge.
- Decode on opcode = instruction[6:0]:
  - I-type, 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM: sext(instr[31:20]).
  - OP-IMM shifts, funct3 001/101: zero-extended shamt instr[24:20]. funct7 (srai bit 30) is excluded.
  - S-type, 0100011: sext({instr[31:25], instr[11:7]}).
  - B-type, 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Always even.
  - U-type, 0110111 LUI and 0010111 AUIPC: {instr[31:12], 12'b0}. No extension.
  - J-type, 1101111 JAL: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type 0110011, FENCE 0001111, and any other opcode: 32'h0.
- Sign bit is always instr[31] for I/S/B/J.
- Any X/illegal opcode bits select the default branch (zero). No error flag.
- Back-to-back instructions each produce their result one edge later. No stalls, no handshake.

Decomposition:
- Shared package rv32_pkg holds:
  - the opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_SYSTEM, OPC_FENCE);
  - an imm_fmt_e enum {FMT_NONE, FMT_I, FMT_SHAMT, FMT_S, FMT_B, FMT_U, FMT_J}.
- One natural sub-module: imm_decode, purely combinational.
  - It takes instruction and returns fmt plus the 32-bit value.
  - immediate_gen wraps it with the async-reset output register.

Test Plan:
- Reset: reset_n=0 with instruction=32'h02a00293 -> immediate=0 with no clock edge. Release reset, then one edge -> 32'h0000002A.
- Sequence, one edge each; each value appears after its capturing edge:
  - 32'h02a00293 addi -> 42;
  - 32'h00052283 lw -> 0;
  - 32'h01c38463 beq -> 8;
  - 32'h006283b3 add -> 0.
- Negative immediates:
  - 32'hFE552E23 sw offset -4 -> 32'hFFFFFFFC;
  - 32'hFFDFF06F jal -4 -> 32'hFFFFFFFC.
- U-type and shift:
  - 32'h123450B7 lui -> 32'h12345000;
  - 32'h4030D093 srai by 3 -> 32'h00000003 (funct7 excluded).
- Mid-stream reset: drive reset_n low between edges while immediate=8 -> immediate drops to 0 immediately. It stays 0 through edges while reset_n is low.
- Random sweep: 1000 random instructions compared against a behavioural reference decode, one-cycle delayed -> zero mismatches.
